// File: rtl/argmax_classifier.sv
// Sequential argmax over a post-ReLU class-score vector: captures the vector,
// scans one score per clock and presents the winning index/score over valid/ready.
module argmax_classifier #(
    parameter int BITWIDTH    = 32,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] featuremap_RELUed [NUM_CLASSES],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    class_idx,
    output logic [BITWIDTH-1:0] class_score,
    output logic                out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_e              state_q, state_d;
    logic [BITWIDTH-1:0] score_buf_q [NUM_CLASSES];
    logic [BITWIDTH-1:0] score_buf_d [NUM_CLASSES];
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [BITWIDTH-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0]    best_idx_q, best_idx_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    class_idx_q, class_idx_d;
    logic [BITWIDTH-1:0] class_score_q, class_score_d;
    logic                out_err_q, out_err_d;

    logic                in_err;
    logic                scan_last;
    logic                cand_gt;
    logic [BITWIDTH-1:0] scan_val;
    logic [IDX_W-1:0]    scan_idx;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default first, otherwise a latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = SCAN;
            SCAN:    if (scan_last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: the handshake flags are pure functions of the state
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Scan datapath: unsigned strict compare, so ties keep the lower index
    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            in_err = in_err | featuremap_RELUed[i][BITWIDTH-1];
        end
        scan_last = (cnt_q == LAST_IDX);
        cand_gt   = (score_buf_q[cnt_q] > best_val_q);
        scan_val  = cand_gt ? score_buf_q[cnt_q] : best_val_q;
        scan_idx  = cand_gt ? cnt_q : best_idx_q;
    end

    always_comb begin
        score_buf_d   = score_buf_q;
        cnt_d         = cnt_q;
        best_val_d    = best_val_q;
        best_idx_d    = best_idx_q;
        err_d         = err_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        out_err_d     = out_err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    score_buf_d = featuremap_RELUed;
                    best_val_d  = featuremap_RELUed[0];
                    best_idx_d  = '0;
                    cnt_d       = IDX_W'(1);
                    err_d       = in_err;
                end
            end
            SCAN: begin
                best_val_d = scan_val;
                best_idx_d = scan_idx;
                if (scan_last) begin
                    // The last compare feeds the result registers directly
                    class_idx_d   = scan_idx;
                    class_score_d = scan_val;
                    out_err_d     = err_q;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the score buffer is a handful of flops that must read as zero after reset, so it is reset like any other register rather than left as an unreset memory.
            for (int i = 0; i < NUM_CLASSES; i++) begin
                score_buf_q[i] <= '0;
            end
            cnt_q         <= '0;
            best_val_q    <= '0;
            best_idx_q    <= '0;
            err_q         <= 1'b0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            out_err_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            score_buf_q   <= score_buf_d;
            cnt_q         <= cnt_d;
            best_val_q    <= best_val_d;
            best_idx_q    <= best_idx_d;
            err_q         <= err_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
            out_err_q     <= out_err_d;
        end
    end

    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;
    assign out_err     = out_err_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: expected results are queued at accept
// time and compared, with latency, when the result handshake completes.
module tb_argmax_classifier;

    localparam int BW  = 32;
    localparam int NC  = 10;
    localparam int IW  = 4;
    localparam int LAT = NC - 1;

    typedef logic [BW-1:0] vec_t [NC];
    typedef struct {
        logic [IW-1:0] idx;
        logic [BW-1:0] score;
        logic          err;
    } result_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    vec_t          fm;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [IW-1:0] class_idx;
    logic [BW-1:0] class_score;
    logic          out_err;

    int      n_checks = 0;
    int      n_fail   = 0;
    int      cyc      = 0;
    result_t exp_q[$];
    int      acc_q[$];

    argmax_classifier #(.BITWIDTH(BW), .NUM_CLASSES(NC), .IDX_W(IW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .featuremap_RELUed(fm),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .class_idx        (class_idx),
        .class_score      (class_score),
        .out_err          (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d results pending, required 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic result_t model(input vec_t v);
        result_t r;
        r.idx   = '0;
        r.score = v[0];
        r.err   = 1'b0;
        for (int i = 0; i < NC; i++) begin
            r.err = r.err | v[i][BW-1];
            if (v[i] > r.score) begin
                r.score = v[i];
                r.idx   = IW'(i);
            end
        end
        return r;
    endfunction

    // Drives a vector and waits for its accept edge; returns the cycle count after that edge.
    task automatic send(input vec_t v, input bit keep_valid, output int acc_cyc);
        int guard;
        @(posedge clk); #1;
        fm       = v;
        in_valid = 1'b1;
        guard    = 0;
        acc_cyc  = -1;
        while (guard < 200) begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
        end
        if (guard >= 200) begin
            check("accept_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            acc_cyc = cyc;
            exp_q.push_back(model(v));
            acc_q.push_back(acc_cyc);
            if (!keep_valid) in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: latency on rising out_valid, scoreboard compare on each handshake
    bit ov_prev = 1'b0;
    bit hs_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) check("done_one_cycle", {63'd0, out_valid}, 64'd0);
            if (out_valid && !ov_prev) begin
                if (acc_q.size() != 0) check("latency", 64'(cyc - acc_q.pop_front()), 64'(LAT));
                else                   check("spurious_valid", {63'd0, out_valid}, 64'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) begin
                    result_t e;
                    e = exp_q.pop_front();
                    check("class_idx",   64'(class_idx),   64'(e.idx));
                    check("class_score", 64'(class_score), 64'(e.score));
                    check("out_err",     64'(out_err),     64'(e.err));
                end else begin
                    check("unexpected_result", {63'd0, out_valid}, 64'd0);
                end
            end
            hs_prev = out_valid && out_ready;
            ov_prev = out_valid;
        end
    end

    initial begin
        vec_t    v;
        vec_t    v2;
        result_t e;
        int      a1, a2, a3, guard;

        // Reset state
        #3;
        check("rst_in_ready",    64'(in_ready),    64'd1);
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_class_idx",   64'(class_idx),   64'd0);
        check("rst_class_score", 64'(class_score), 64'd0);
        check("rst_out_err",     64'(out_err),     64'd0);
        #20 rst_n = 1'b1;

        // 1) basic vector
        v = '{32'd3, 32'd9, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7};
        send(v, 1'b0, a1);
        drain();

        // 2) tie rule and max at the last index
        for (int i = 0; i < NC; i++) v[i] = 32'd5;
        send(v, 1'b0, a1);
        for (int i = 0; i < NC; i++) v[i] = 32'(i);
        v[NC-1] = 32'd100;
        send(v, 1'b0, a1);
        drain();

        // All-zero vector
        for (int i = 0; i < NC; i++) v[i] = '0;
        send(v, 1'b0, a1);
        drain();

        // 4) MSB-set score wins on unsigned compare and raises out_err
        for (int i = 0; i < NC; i++) v[i] = 32'(i + 2);
        v[4] = 32'h8000_0001;
        send(v, 1'b0, a1);
        drain();

        // 3) downstream stall for 20 cycles with a competing in_valid
        out_ready = 1'b0;
        v = '{32'd10, 32'd20, 32'd30, 32'd44, 32'd2, 32'd44, 32'd1, 32'd0, 32'd3, 32'd4};
        e = model(v);
        send(v, 1'b0, a1);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("stall_valid_seen", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #1;
        for (int i = 0; i < NC; i++) v2[i] = 32'd1000 + 32'(i);
        fm       = v2;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("stall_out_valid",   64'(out_valid),   64'd1);
            check("stall_in_ready",    64'(in_ready),    64'd0);
            check("stall_class_idx",   64'(class_idx),   64'(e.idx));
            check("stall_class_score", 64'(class_score), 64'(e.score));
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_stall_in_ready", 64'(in_ready), 64'd1);
        drain();

        // 5) reset in the middle of a scan (cnt == 5)
        for (int i = 0; i < NC; i++) v[i] = 32'd50 - 32'(i);
        send(v, 1'b0, a1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        #1;
        check("midscan_rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("post_rst_no_valid", 64'(out_valid), 64'd0);
        end
        v = '{32'd7, 32'd7, 32'd8, 32'd1, 32'd8, 32'd0, 32'd2, 32'd3, 32'd4, 32'd5};
        send(v, 1'b0, a1);
        drain();

        // 6) back-to-back vectors with in_valid held high
        for (int i = 0; i < NC; i++) v[i] = 32'(i * 3);
        send(v, 1'b1, a1);
        for (int i = 0; i < NC; i++) v[i] = 32'd90 - 32'(i * 3);
        send(v, 1'b1, a2);
        for (int i = 0; i < NC; i++) v[i] = 32'd6;
        v[6] = 32'd60;
        send(v, 1'b0, a3);
        check("b2b_period_1", 64'(a2 - a1), 64'(NC + 1));
        check("b2b_period_2", 64'(a3 - a2), 64'(NC + 1));
        drain();

        // Random vectors, some with MSBs set
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NC; i++) begin
                v[i] = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_00FF);
            end
            send(v, 1'b0, a1);
        end
        drain();

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
